key_count_ctrl: RTL and testbench
=================================

// Module: key_count_ctrl
// PURPOSE
//  Controller between the key debouncers and the BCD/7-seg display path.
//  - Turns two debounced key levels into count commands: up, down, clear, and auto-repeat on long press.
//  - Owns the 8-bit count register.
//  - Sequences a multi-cycle BCD converter through a start/done handshake.
//  - Presents a 24-bit, leading-zero-blanked digit word to the seg7 scanner.
// PARAMETERS
//  CNT_MAX   255         upper count limit; 1..255
//  WRAP      1           1: wrap at the limits (CNT_MAX+1 -> 0, 0-1 -> CNT_MAX); 0: saturate
//  HOLD_CYC  50_000_000  cycles a key must be held before auto-repeat starts
//  REP_CYC   10_000_000  cycles between auto-repeat steps
//  TO_CYC    64          converter done timeout, in cycles
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   async reset, active low
//  key_up     in   1   debounced level, 1 = pressed
//  key_dn     in   1   debounced level, 1 = pressed
//  data_bin   out  8   current count
//  bcd_start  out  1   one-cycle pulse; converter samples data_bin
//  bcd_done   in   1   one-cycle pulse; digits are valid
//  bcd_h/t/o  in   4   hundreds / tens / ones from the converter
//  disp_data  out  24  {d5..d0} nibbles to seg7; 4'hF = blank digit
//  conv_err   out  1   sticky converter timeout flag; cleared only by reset
// BEHAVIOUR
//  Clock and reset
//  - One clock; reset is asynchronous and active-low (clk, rst_n).
//  - Reset values: data_bin=0, bcd_start=0, conv_err=0, disp_data=24'hFF0FFF.
//  - Reset returns both FSMs to IDLE and zeroes all timers, including mid-conversion.
//  Key input
//  - Register key_up/key_dn once; detect rising edges on the registered levels.
//  Key FSM: IDLE, HOLD, REPEAT, BOTH
//  - IDLE -> HOLD on a rising edge of exactly one key. Step the count once; data_bin changes 1 cycle after the edge.
//  - HOLD: the timer counts while the same key stays held.
//    - Timer reaches HOLD_CYC: step the count and go to REPEAT.
//    - Key released: go to IDLE.
//  - REPEAT: step the count every REP_CYC cycles while held; release -> IDLE.
//  - Both keys high in any state (simultaneous edges, or second key pressed while the first is held):
//    - data_bin := 0 on the next cycle; go to BOTH.
//    - No steps occur in BOTH.
//    - BOTH -> IDLE only when both keys are low. A key still held on exit does not step.
//  Step arithmetic
//  - Up at CNT_MAX: WRAP=1 -> 0; WRAP=0 -> hold at CNT_MAX.
//  - Down at 0: WRAP=1 -> CNT_MAX; WRAP=0 -> hold at 0.
//  Conversion FSM: C_IDLE, C_WAIT
//  - Any write to data_bin (step or clear, even when the value is unchanged) sets pend.
//  - C_IDLE with pend=1: pulse bcd_start for 1 cycle, clear pend, go to C_WAIT, start the timeout counter.
//  - C_WAIT, bcd_done: latch bcd_h/t/o into disp_data and go to C_IDLE. A pend set during C_WAIT triggers a new start on the following cycle, so the display always converges to the final count.
//  - C_WAIT, TO_CYC cycles without done: set conv_err, keep the old disp_data, go to C_IDLE.
//  - bcd_done while in C_IDLE is ignored.
//  - A write to data_bin in the same cycle as bcd_done: latch the digits and set pend.
//  - Display latency: edge -> data_bin +1; -> bcd_start +2; disp_data updates 1 cycle after bcd_done.
//  Display word
//  - disp_data = {H,T,O,F,F,F}, with leading-zero blanking:
//    - H=F when h=0.
//    - T=F when h=0 and t=0.
//    - Ones digit is always shown.
//  - Examples: count 7 -> 24'hFF7FFF; count 40 -> 24'hF40FFF; count 205 -> 24'h205FFF.
// STRUCTURE
//  - Shared package key_count_pkg:
//    - key FSM state typedef: IDLE/HOLD/REPEAT/BOTH.
//    - conversion FSM state typedef: C_IDLE/C_WAIT.
//    - BLANK_DIGIT = 4'hF.
//  - Sub-module key_repeat_timer: per-press timer that emits step pulses for HOLD/REPEAT; reset by release.
//  - Count register, conversion FSM and blanking logic stay in this module.
//  - Bench converter model bcd_seq_model: returns bcd_done a programmable number of cycles after bcd_start, or never.
// TESTING
//  1. Reset, then press key_up once (HOLD_CYC=20) -> data_bin=1; one bcd_start; model done -> disp_data=24'hFF1FFF.
//  2. Hold key_up for 20+3*8 cycles (HOLD_CYC=20, REP_CYC=8) -> data_bin=5 (1 on press + 1 at hold + 3 repeats).
//  3. Count 255, WRAP=1, press up -> data_bin=0. WRAP=0: 255 stays 255, 0 down stays 0.
//  4. key_up held, then key_dn pressed -> data_bin=0; no steps until both released; press up after release -> 1.
//  5. Model latency 30, three presses within 10 cycles -> exactly 2 bcd_start pulses; final disp_data=24'hFF3FFF.
//  6. Model never returns done (TO_CYC=64) -> conv_err=1 at cycle 64, disp_data unchanged. rst_n low mid-C_WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/key_count_pkg.sv
// Shared types for the key/count controller: key and conversion FSM states
// plus the digit code the seg7 scanner shows as blank.
package key_count_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BOTH} key_state_t;
   typedef enum logic {C_IDLE, C_WAIT} conv_state_t;
   localparam logic [3:0] BLANK_DIGIT = 4'hF;
endpackage

// File: rtl/key_count_ctrl_if.sv
// Start/done handshake and digit bus between the controller and the
// multi-cycle BCD converter.
interface key_count_ctrl_if;
   logic       bcd_start;
   logic       bcd_done;
   logic [3:0] bcd_h;
   logic [3:0] bcd_t;
   logic [3:0] bcd_o;

   modport master (output bcd_start, input bcd_done, bcd_h, bcd_t, bcd_o);
   modport slave  (input bcd_start, output bcd_done, bcd_h, bcd_t, bcd_o);
endinterface

// File: rtl/key_repeat_timer.sv
// Per-press hold timer: one step pulse after HOLD_CYC held cycles, then one
// every REP_CYC cycles; a release (run low) clears it. HOLD_CYC must be >= 2.
module key_repeat_timer #(
   parameter int unsigned HOLD_CYC = 50_000_000,
   parameter int unsigned REP_CYC  = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   output logic step
);
   localparam int unsigned MAX_CYC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int W = $clog2(MAX_CYC + 1);

   logic [W-1:0] cnt;
   logic [W-1:0] limit;
   logic         repeating;

   // cnt holds (held cycles - 1); the press-edge cycle counts as the first held cycle
   assign limit = repeating ? W'(REP_CYC - 1) : W'(HOLD_CYC - 1);
   assign step  = run && (cnt == limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         repeating <= 1'b0;
      end else if (start) begin
         cnt       <= W'(1);
         repeating <= 1'b0;
      end else if (!run) begin
         cnt       <= '0;
         repeating <= 1'b0;
      end else if (step) begin
         cnt       <= '0;
         repeating <= 1'b1;
      end else begin
         cnt       <= cnt + W'(1);
      end
   end
endmodule

// File: rtl/key_count_ctrl.sv
// Key-to-count controller: up/down/clear/auto-repeat on the count register,
// sequencing of the BCD converter and the leading-zero-blanked display word.
module key_count_ctrl
   import key_count_pkg::*;
#(
   parameter int unsigned CNT_MAX  = 255,
   parameter int unsigned WRAP     = 1,
   parameter int unsigned HOLD_CYC = 50_000_000,
   parameter int unsigned REP_CYC  = 10_000_000,
   parameter int unsigned TO_CYC   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_up,
   input  logic             key_dn,
   output logic [7:0]       data_bin,
   key_count_ctrl_if.master bcd,
   output logic [23:0]      disp_data,
   output logic             conv_err
);
   localparam int TO_W = $clog2(TO_CYC + 1);
   localparam logic [23:0] DISP_RST = {BLANK_DIGIT, BLANK_DIGIT, 4'd0,
                                       BLANK_DIGIT, BLANK_DIGIT, BLANK_DIGIT};

   key_state_t      key_state;
   conv_state_t     conv_state;
   logic            up_q, dn_q, up_prev, dn_prev;
   logic            single_up, single_dn, both, press, held, run, step, dir_up;
   logic            wr, pend;
   logic [7:0]      next_bin;
   logic [TO_W-1:0] to_cnt;

   function automatic logic [7:0] step_count(input logic [7:0] v, input logic up);
      logic [7:0] lim;
      lim = 8'(CNT_MAX);
      if (up) return (v >= lim) ? ((WRAP != 0) ? 8'd0 : lim) : v + 8'd1;
      return (v == 8'd0) ? ((WRAP != 0) ? lim : 8'd0) : v - 8'd1;
   endfunction

   function automatic logic [23:0] blank_digits(input logic [3:0] h, t, o);
      logic [3:0] dh, dt;
      dh = (h == 4'd0) ? BLANK_DIGIT : h;
      dt = (h == 4'd0 && t == 4'd0) ? BLANK_DIGIT : t;
      return {dh, dt, o, BLANK_DIGIT, BLANK_DIGIT, BLANK_DIGIT};
   endfunction

   assign both      = up_q & dn_q;
   assign single_up = up_q & ~up_prev & ~dn_q;
   assign single_dn = dn_q & ~dn_prev & ~up_q;
   assign press     = (single_up | single_dn) && (key_state != BOTH);
   assign held      = dir_up ? up_q : dn_q;
   assign run       = (key_state == HOLD || key_state == REPEAT) && held && !both;

   key_repeat_timer #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (press),
      .run   (run),
      .step  (step)
   );

   // Clear is written only on entry to BOTH so a long two-key hold does not
   // keep re-triggering conversions.
   always_comb begin
      wr       = 1'b0;
      next_bin = data_bin;
      if (both && key_state != BOTH) begin
         wr       = 1'b1;
         next_bin = 8'd0;
      end else if (press) begin
         wr       = 1'b1;
         next_bin = step_count(data_bin, single_up);
      end else if (step) begin
         wr       = 1'b1;
         next_bin = step_count(data_bin, dir_up);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_q      <= 1'b0;
         dn_q      <= 1'b0;
         up_prev   <= 1'b0;
         dn_prev   <= 1'b0;
         dir_up    <= 1'b1;
         data_bin  <= 8'd0;
         key_state <= IDLE;
      end else begin
         up_q    <= key_up;
         dn_q    <= key_dn;
         up_prev <= up_q;
         dn_prev <= dn_q;
         if (wr) data_bin <= next_bin;
         case (key_state)
            BOTH: if (!up_q && !dn_q) key_state <= IDLE;
            default: begin
               if (both) key_state <= BOTH;
               else if (press) begin
                  key_state <= HOLD;
                  dir_up    <= single_up;
               end
               else if (key_state != IDLE && !held) key_state <= IDLE;
               else if (step) key_state <= REPEAT;
            end
         endcase
      end
   end

   // pend remembers any count write not yet handed to the converter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_state    <= C_IDLE;
         pend          <= 1'b0;
         bcd.bcd_start <= 1'b0;
         to_cnt        <= '0;
         conv_err      <= 1'b0;
         disp_data     <= DISP_RST;
      end else begin
         bcd.bcd_start <= 1'b0;
         if (wr) pend <= 1'b1;
         case (conv_state)
            C_IDLE: if (pend) begin
               bcd.bcd_start <= 1'b1;
               pend          <= wr;
               to_cnt        <= '0;
               conv_state    <= C_WAIT;
            end
            C_WAIT: begin
               if (bcd.bcd_done) begin
                  disp_data  <= blank_digits(bcd.bcd_h, bcd.bcd_t, bcd.bcd_o);
                  conv_state <= C_IDLE;
               end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                  conv_err   <= 1'b1;
                  conv_state <= C_IDLE;
               end else begin
                  to_cnt     <= to_cnt + TO_W'(1);
               end
            end
            default: conv_state <= C_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_count_ctrl.sv
// Bench for key_count_ctrl: a wrapping and a saturating instance, a behavioural
// BCD converter with programmable latency, and a count/display reference model.
module tb_key_count_ctrl;
   localparam int H = 20, R = 8, TO = 64, CMAX = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        up0 = 1'b0, dn0 = 1'b0, up1 = 1'b0, dn1 = 1'b0;
   logic [7:0]  bin0, bin1;
   logic [23:0] disp0, disp1;
   logic        err0, err1;
   int          total = 0, bad = 0;
   int          lat = 4;
   int          starts = 0, starts1 = 0;
   int          cd;
   logic [7:0]  cap;

   key_count_ctrl_if bus0();
   key_count_ctrl_if bus1();

   always #5 clk = ~clk;

   key_count_ctrl #(.CNT_MAX(CMAX), .WRAP(1), .HOLD_CYC(H), .REP_CYC(R), .TO_CYC(TO)) dut0 (
      .clk(clk), .rst_n(rst_n), .key_up(up0), .key_dn(dn0), .data_bin(bin0),
      .bcd(bus0), .disp_data(disp0), .conv_err(err0));

   key_count_ctrl #(.CNT_MAX(CMAX), .WRAP(0), .HOLD_CYC(H), .REP_CYC(R), .TO_CYC(TO)) dut1 (
      .clk(clk), .rst_n(rst_n), .key_up(up1), .key_dn(dn1), .data_bin(bin1),
      .bcd(bus1), .disp_data(disp1), .conv_err(err1));

   assign bus1.bcd_done = 1'b0;
   assign bus1.bcd_h    = 4'd0;
   assign bus1.bcd_t    = 4'd0;
   assign bus1.bcd_o    = 4'd0;

   // Converter model: done 'lat' cycles after sampling start; lat < 0 never answers.
   always @(posedge clk or negedge rst_n) begin : bcd_seq_model
      if (!rst_n) begin
         cd <= -1;
         cap <= 8'd0;
         bus0.bcd_done <= 1'b0;
         bus0.bcd_h <= 4'd0;
         bus0.bcd_t <= 4'd0;
         bus0.bcd_o <= 4'd0;
      end else begin
         bus0.bcd_done <= 1'b0;
         if (bus0.bcd_start) begin
            cap <= bin0;
            cd  <= lat;
         end else if (cd > 0) begin
            cd <= cd - 1;
         end else if (cd == 0) begin
            bus0.bcd_done <= 1'b1;
            bus0.bcd_h <= 4'(cap / 100);
            bus0.bcd_t <= 4'((cap / 10) % 10);
            bus0.bcd_o <= 4'(cap % 10);
            cd <= -1;
         end
      end
   end

   always @(posedge clk) begin
      if (bus0.bcd_start) starts <= starts + 1;
      if (bus1.bcd_start) starts1 <= starts1 + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int steps_for_hold(input int n);
      return (n >= H) ? 2 + (n - H) / R : 1;
   endfunction

   function automatic int model_step(input int c, input bit up, input bit wrap);
      if (wrap) return up ? (c + 1) % (CMAX + 1) : (c + CMAX) % (CMAX + 1);
      return up ? ((c < CMAX) ? c + 1 : CMAX) : ((c > 0) ? c - 1 : 0);
   endfunction

   function automatic int model_press(input int c, input bit up, input int n, input bit wrap);
      int r = c;
      for (int i = 0; i < steps_for_hold(n); i++) r = model_step(r, up, wrap);
      return r;
   endfunction

   function automatic logic [23:0] model_disp(input int c);
      int h, t, o;
      logic [3:0] dh, dt;
      h = c / 100; t = (c / 10) % 10; o = c % 10;
      dh = (h == 0) ? 4'hF : 4'(h);
      dt = (h == 0 && t == 0) ? 4'hF : 4'(t);
      return {dh, dt, 4'(o), 12'hFFF};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; up0 = 1'b0; dn0 = 1'b0; up1 = 1'b0; dn1 = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic set_keys(input int which, input bit u, input bit d);
      if (which == 0) begin up0 = u; dn0 = d; end
      else begin up1 = u; dn1 = d; end
   endtask

   task automatic press(input int which, input bit u, input bit d, input int n, input int gap);
      set_keys(which, u, d);
      cyc(n);
      set_keys(which, 1'b0, 1'b0);
      cyc(gap);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus0.bcd_done) begin ok = 1'b1; break; end
         cyc(1);
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus0.bcd_start) begin ok = 1'b1; break; end
         cyc(1);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL reset_bin: got %0d want 0", bin0); end
      total++; if (disp0 !== 24'hFF0FFF) begin bad++; $display("FAIL reset_disp: got %06h want ff0fff", disp0); end
      total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err0); end
      total++; if (bus0.bcd_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %0b want 0", bus0.bcd_start); end
      total++; if (bin1 !== 8'd0) begin bad++; $display("FAIL reset_bin1: got %0d want 0", bin1); end
   endtask

   task automatic test_single_press();
      int s0;
      bit ok;
      do_reset();
      lat = 4;
      s0 = starts;
      up0 = 1'b1;
      cyc(1);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL single_early: got %0d want 0", bin0); end
      cyc(1);
      total++; if (bin0 !== 8'd1) begin bad++; $display("FAIL single_bin: got %0d want 1", bin0); end
      total++; if (bus0.bcd_start !== 1'b0) begin bad++; $display("FAIL single_start_early: got %0b want 0", bus0.bcd_start); end
      cyc(1);
      total++; if (bus0.bcd_start !== 1'b1) begin bad++; $display("FAIL single_start: got %0b want 1", bus0.bcd_start); end
      up0 = 1'b0;
      wait_done(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_done_timeout: got none want bcd_done"); end
      total++; if (disp0 !== 24'hFF0FFF) begin bad++; $display("FAIL single_disp_old: got %06h want ff0fff", disp0); end
      cyc(1);
      total++; if (disp0 !== 24'hFF1FFF) begin bad++; $display("FAIL single_disp: got %06h want ff1fff", disp0); end
      cyc(5);
      total++; if (starts - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d want 1", starts - s0); end
   endtask

   task automatic test_hold_repeat();
      int c;
      do_reset();
      c = 0;
      press(0, 1'b1, 1'b0, H + 3 * R, 4);
      c = model_press(c, 1'b1, H + 3 * R, 1'b1);
      total++; if (bin0 !== 8'(c) || c != 5) begin bad++; $display("FAIL hold_44: got %0d want %0d", bin0, c); end
      press(0, 1'b1, 1'b0, H - 1, 4);
      c = model_press(c, 1'b1, H - 1, 1'b1);
      total++; if (bin0 !== 8'(c)) begin bad++; $display("FAIL hold_19: got %0d want %0d", bin0, c); end
      press(0, 1'b1, 1'b0, H, 4);
      c = model_press(c, 1'b1, H, 1'b1);
      total++; if (bin0 !== 8'(c)) begin bad++; $display("FAIL hold_20: got %0d want %0d", bin0, c); end
      press(0, 1'b0, 1'b1, H + R, 4);
      c = model_press(c, 1'b0, H + R, 1'b1);
      total++; if (bin0 !== 8'(c)) begin bad++; $display("FAIL hold_dn: got %0d want %0d", bin0, c); end
   endtask

   task automatic test_wrap_saturate();
      int c1;
      do_reset();
      press(0, 1'b0, 1'b1, 2, 4);
      total++; if (bin0 !== 8'd255) begin bad++; $display("FAIL wrap_down: got %0d want 255", bin0); end
      press(0, 1'b1, 1'b0, 2, 4);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL wrap_up: got %0d want 0", bin0); end
      c1 = 0;
      press(1, 1'b0, 1'b1, 2, 4);
      c1 = model_press(c1, 1'b0, 2, 1'b0);
      total++; if (bin1 !== 8'(c1)) begin bad++; $display("FAIL sat_down: got %0d want %0d", bin1, c1); end
      press(1, 1'b1, 1'b0, 2100, 4);
      c1 = model_press(c1, 1'b1, 2100, 1'b0);
      total++; if (bin1 !== 8'(c1)) begin bad++; $display("FAIL sat_hold: got %0d want %0d", bin1, c1); end
      press(1, 1'b1, 1'b0, 2, 4);
      c1 = model_press(c1, 1'b1, 2, 1'b0);
      total++; if (bin1 !== 8'(c1)) begin bad++; $display("FAIL sat_up: got %0d want %0d", bin1, c1); end
      total++; if (err1 !== 1'b1) begin bad++; $display("FAIL sat_conv_err: got %0b want 1", err1); end
      total++; if (disp1 !== 24'hFF0FFF) begin bad++; $display("FAIL sat_disp: got %06h want ff0fff", disp1); end
      total++; if (starts1 < 1) begin bad++; $display("FAIL sat_starts: got %0d want >=1", starts1); end
   endtask

   task automatic test_both_keys();
      int c;
      do_reset();
      up0 = 1'b1;
      cyc(30);
      c = model_press(0, 1'b1, 30, 1'b1);
      total++; if (bin0 !== 8'(c)) begin bad++; $display("FAIL both_pre: got %0d want %0d", bin0, c); end
      dn0 = 1'b1;
      cyc(3);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL both_clear: got %0d want 0", bin0); end
      cyc(40);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL both_hold: got %0d want 0", bin0); end
      dn0 = 1'b0;
      cyc(30);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL both_one_left: got %0d want 0", bin0); end
      up0 = 1'b0;
      cyc(4);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL both_exit: got %0d want 0", bin0); end
      press(0, 1'b1, 1'b0, 2, 4);
      total++; if (bin0 !== 8'd1) begin bad++; $display("FAIL both_after: got %0d want 1", bin0); end
      press(0, 1'b1, 1'b1, 5, 4);
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL both_simul: got %0d want 0", bin0); end
   endtask

   task automatic test_back_to_back();
      int s0;
      do_reset();
      lat = 30;
      s0 = starts;
      for (int i = 0; i < 3; i++) press(0, 1'b1, 1'b0, 1, 2);
      cyc(120);
      total++; if (starts - s0 !== 2) begin bad++; $display("FAIL b2b_starts: got %0d want 2", starts - s0); end
      total++; if (bin0 !== 8'd3) begin bad++; $display("FAIL b2b_bin: got %0d want 3", bin0); end
      total++; if (disp0 !== 24'hFF3FFF) begin bad++; $display("FAIL b2b_disp: got %06h want ff3fff", disp0); end
      total++; if (err0 !== 1'b0) begin bad++; $display("FAIL b2b_err: got %0b want 0", err0); end
   endtask

   task automatic test_timeout();
      bit ok;
      int s0;
      do_reset();
      lat = -1;
      up0 = 1'b1;
      cyc(1);
      up0 = 1'b0;
      wait_start(10, ok);
      total++; if (!ok) begin bad++; $display("FAIL to_start: got none want bcd_start"); end
      cyc(TO - 1);
      total++; if (err0 !== 1'b0) begin bad++; $display("FAIL to_early: got %0b want 0", err0); end
      cyc(1);
      total++; if (err0 !== 1'b1) begin bad++; $display("FAIL to_err: got %0b want 1", err0); end
      total++; if (disp0 !== 24'hFF0FFF) begin bad++; $display("FAIL to_disp: got %06h want ff0fff", disp0); end
      press(0, 1'b1, 1'b0, 1, 0);
      wait_start(10, ok);
      total++; if (!ok) begin bad++; $display("FAIL to_start2: got none want bcd_start"); end
      cyc(10);
      total++; if (err0 !== 1'b1 || bin0 !== 8'd2) begin bad++; $display("FAIL to_sticky: got err=%0b bin=%0d want err=1 bin=2", err0, bin0); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (bin0 !== 8'd0) begin bad++; $display("FAIL midrst_bin: got %0d want 0", bin0); end
      total++; if (bus0.bcd_start !== 1'b0) begin bad++; $display("FAIL midrst_start: got %0b want 0", bus0.bcd_start); end
      total++; if (err0 !== 1'b0) begin bad++; $display("FAIL midrst_err: got %0b want 0", err0); end
      total++; if (disp0 !== 24'hFF0FFF) begin bad++; $display("FAIL midrst_disp: got %06h want ff0fff", disp0); end
      #1 rst_n = 1'b1;
      s0 = starts;
      cyc(80);
      total++; if (starts - s0 !== 0 || err0 !== 1'b0) begin bad++; $display("FAIL midrst_idle: got starts=%0d err=%0b want 0 0", starts - s0, err0); end
   endtask

   task automatic test_random();
      int c, kind, n, gap;
      do_reset();
      lat = $urandom_range(1, 12);
      c = 0;
      for (int i = 0; i < 14; i++) begin
         kind = $urandom_range(0, 4);
         gap  = $urandom_range(4, 8);
         case (kind)
            0, 1: n = $urandom_range(1, 15);
            2, 3: n = $urandom_range(20, 60);
            default: n = $urandom_range(1, 6);
         endcase
         if (kind == 4) begin
            press(0, 1'b1, 1'b1, n, gap);
            c = 0;
         end else begin
            press(0, (kind % 2) == 0, (kind % 2) == 1, n, gap);
            c = model_press(c, (kind % 2) == 0, n, 1'b1);
         end
         total++; if (bin0 !== 8'(c)) begin bad++; $display("FAIL rand_bin[%0d]: kind=%0d n=%0d got %0d want %0d", i, kind, n, bin0, c); end
      end
      cyc(150);
      total++; if (disp0 !== model_disp(c)) begin bad++; $display("FAIL rand_disp: got %06h want %06h", disp0, model_disp(c)); end
      total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rand_err: got %0b want 0", err0); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_hold_repeat();
      test_wrap_saturate();
      test_both_keys();
      test_back_to_back();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
